// File: rtl/wu_fetch.sv
// ---------------------------------------------------------------------------
// wu_fetch : work-unit instruction fetch sequencer
//
// Once the manager pulses start, this block issues one read per cycle into
// the WU instruction memory, starting at start_addr. It follows the memory
// stall and keeps a credit count so that the decode skid buffer never
// overflows. When decode reports end-of-program, fetching stops. The block
// then waits for every outstanding word to be consumed and pulses done.
//
// Optional feature macro: WU_FETCH_LOOP_EN
//   When defined, the loop_count port exists and the program runs
//   loop_count+1 passes, each one starting again at start_addr.
//
// Ports
//   clk                      in   system clock, rising edge
//   reset_poweron            in   asynchronous active-low reset
//   mcntl__wuf__start        in   single-cycle start pulse (accepted in IDLE only)
//   mcntl__wuf__start_addr   in   first WU address, sampled with start
//   mcntl__wuf__loop_count   in   extra passes, sampled with start (loop build only)
//   wuf__mcntl__busy         out  high in any state other than IDLE
//   wuf__mcntl__done         out  one-cycle pulse after the program has drained
//   wuf__mcntl__err          out  sticky credit-overflow error
//   wuf__wum__addr           out  registered read address
//   wuf__wum__read           out  registered read strobe, one word per high cycle
//   wum__wuf__stall          in   memory/decode backpressure
//   wud__wuf__consume        in   decode retired one word from its skid buffer
//   wud__wuf__end            in   decode saw the last instruction (pulse)
// ---------------------------------------------------------------------------
module wu_fetch #(
    parameter int ADDR_W  = 10,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              mcntl__wuf__start,
    input  logic [ADDR_W-1:0] mcntl__wuf__start_addr,
`ifdef WU_FETCH_LOOP_EN
    input  logic [7:0]        mcntl__wuf__loop_count,
`endif
    output logic              wuf__mcntl__busy,
    output logic              wuf__mcntl__done,
    output logic              wuf__mcntl__err,
    output logic [ADDR_W-1:0] wuf__wum__addr,
    output logic              wuf__wum__read,
    input  logic              wum__wuf__stall,
    input  logic              wud__wuf__consume,
    input  logic              wud__wuf__end
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   pc_q,      pc_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                read_q,    read_d;
    logic [3:0]          credits_q, credits_d;
    logic                err_q,     err_d;
    logic                issue;
    logic                loop_pending;

`ifdef WU_FETCH_LOOP_EN
    logic [7:0]          loop_rem_q, loop_rem_d;
    logic [ADDR_W-1:0]   base_q,     base_d;

    assign loop_pending = (loop_rem_q != 8'd0);
`else
    assign loop_pending = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        credits_d = credits_q;
        err_d     = err_q;
        issue     = 1'b0;
`ifdef WU_FETCH_LOOP_EN
        loop_rem_d = loop_rem_q;
        base_d     = base_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (mcntl__wuf__start) begin
                    pc_d    = mcntl__wuf__start_addr;
`ifdef WU_FETCH_LOOP_EN
                    base_d     = mcntl__wuf__start_addr;
                    loop_rem_d = mcntl__wuf__loop_count;
`endif
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // End wins over a read in the same cycle: nothing past the
                // program's last word is requested once decode has seen it.
                if (wud__wuf__end) begin
                    state_d = ST_DRAIN;
                end else if (!wum__wuf__stall && (credits_q != 4'd0)) begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                // All credits back means every launched word, including any
                // overfetch past the end, has been consumed by decode.
                if (credits_q == CRED_MAX) begin
                    if (loop_pending) begin
`ifdef WU_FETCH_LOOP_EN
                        loop_rem_d = loop_rem_q - 8'd1;
                        pc_d       = base_q;
`endif
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_d = issue;
        if (issue) begin
            addr_d = pc_q;
            pc_d   = pc_q + ADDR_W'(1);
        end

        // Credit bookkeeping: a consume with the counter already full and no
        // read in the same cycle is a protocol violation; hold and flag it.
        case ({issue, wud__wuf__consume})
            2'b10: credits_d = credits_q - 4'd1;
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + 4'd1;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
`ifdef WU_FETCH_LOOP_EN
            loop_rem_q <= 8'd0;
            base_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            credits_q <= credits_d;
            err_q     <= err_d;
`ifdef WU_FETCH_LOOP_EN
            loop_rem_q <= loop_rem_d;
            base_q     <= base_d;
`endif
        end
    end

    assign wuf__mcntl__busy = (state_q != ST_IDLE);
    assign wuf__mcntl__done = (state_q == ST_DONE);
    assign wuf__mcntl__err  = err_q;
    assign wuf__wum__addr   = addr_q;
    assign wuf__wum__read   = read_q;

endmodule

// File: tb/tb_wu_fetch.sv
// ---------------------------------------------------------------------------
// tb_wu_fetch : directed self-checking bench for wu_fetch.
// Inputs change 1 time unit after a rising edge, so they are sampled at the
// next rising edge. Outputs are checked 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_wu_fetch;

    localparam int ADDR_W  = 10;
    localparam int CREDITS = 4;

    logic              clk;
    logic              reset_poweron;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        loop_count;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              stall;
    logic              consume;
    logic              wend;

    int checks;
    int errors;

    wu_fetch #(
        .ADDR_W  (ADDR_W),
        .CREDITS (CREDITS)
    ) dut (
        .clk                    (clk),
        .reset_poweron          (reset_poweron),
        .mcntl__wuf__start      (start),
        .mcntl__wuf__start_addr (start_addr),
`ifdef WU_FETCH_LOOP_EN
        .mcntl__wuf__loop_count (loop_count),
`endif
        .wuf__mcntl__busy       (busy),
        .wuf__mcntl__done       (done),
        .wuf__mcntl__err        (err),
        .wuf__wum__addr         (addr),
        .wuf__wum__read         (read),
        .wum__wuf__stall        (stall),
        .wud__wuf__consume      (consume),
        .wud__wuf__end          (wend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset_poweron = 1'b0;
        stall = 1'b1; start = 1'b0; consume = 1'b0; wend = 1'b0;
        start_addr = '0; loop_count = 8'd0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (err  !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read got %0b want 0", read); end
        checks++; if (addr !== 10'h000) begin errors++; $display("FAIL reset_addr got %h want 000", addr); end
        reset_poweron = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] ea;
        stall = 1'b0;
        pulse_start(10'h010);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy_start got %0b want 1", busy); end
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL stream_read_start got %0b want 0", read); end
        for (int k = 1; k <= 14; k++) begin
            consume = (k >= 4 && k <= 12);
            wend    = (k == 10);
            tick();
            ea = 10'(16 + k - 1);
            checks++;
            if (read !== (k <= 9)) begin errors++; $display("FAIL stream_read k=%0d got %0b want %0b", k, read, (k <= 9)); end
            if (k <= 9) begin
                checks++;
                if (addr !== ea) begin errors++; $display("FAIL stream_addr k=%0d got %h want %h", k, addr, ea); end
            end
            checks++;
            if (done !== (k == 13)) begin errors++; $display("FAIL stream_done k=%0d got %0b want %0b", k, done, (k == 13)); end
            checks++;
            if (busy !== (k <= 13)) begin errors++; $display("FAIL stream_busy k=%0d got %0b want %0b", k, busy, (k <= 13)); end
        end
        consume = 1'b0; wend = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err got %0b want 0", err); end
    endtask

    task automatic test_stall();
        logic [ADDR_W-1:0] ea;
        logic              er;
        int                nrd;
        nrd = 0;
        stall = 1'b0;
        pulse_start(10'h020);
        for (int k = 1; k <= 21; k++) begin
            stall   = (k >= 3 && k <= 7);
            consume = (k == 12) || (k >= 16 && k <= 19);
            wend    = (k == 15);
            tick();
            er = (k == 1) || (k == 2) || (k == 8) || (k == 9) || (k == 13);
            checks++;
            if (read !== er) begin errors++; $display("FAIL stall_read k=%0d got %0b want %0b", k, read, er); end
            if (er) begin
                ea = 10'(32 + nrd);
                nrd++;
                checks++;
                if (addr !== ea) begin errors++; $display("FAIL stall_addr k=%0d got %h want %h", k, addr, ea); end
            end
            checks++;
            if (done !== (k == 20)) begin errors++; $display("FAIL stall_done k=%0d got %0b want %0b", k, done, (k == 20)); end
            checks++;
            if (busy !== (k <= 20)) begin errors++; $display("FAIL stall_busy k=%0d got %0b want %0b", k, busy, (k <= 20)); end
        end
        stall = 1'b0; consume = 1'b0; wend = 1'b0;
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        pulse_start(10'h3FE);
        for (int k = 1; k <= 11; k++) begin
            consume = (k >= 6 && k <= 9);
            wend    = (k == 5);
            tick();
            checks++;
            if (read !== (k <= 4)) begin errors++; $display("FAIL wrap_read k=%0d got %0b want %0b", k, read, (k <= 4)); end
            if (k <= 4) begin
                checks++;
                if (addr !== exp_a[k-1]) begin errors++; $display("FAIL wrap_addr k=%0d got %h want %h", k, addr, exp_a[k-1]); end
            end
            checks++;
            if (done !== (k == 10)) begin errors++; $display("FAIL wrap_done k=%0d got %0b want %0b", k, done, (k == 10)); end
            checks++;
            if (busy !== (k <= 10)) begin errors++; $display("FAIL wrap_busy k=%0d got %0b want %0b", k, busy, (k <= 10)); end
        end
        consume = 1'b0; wend = 1'b0;
    endtask

`ifdef WU_FETCH_LOOP_EN
    task automatic test_loop();
        logic [ADDR_W-1:0] ea;
        logic              er;
        int                m;
        loop_count = 8'd2;
        pulse_start(10'h040);
        for (int k = 1; k <= 25; k++) begin
            m       = k % 8;
            consume = (m >= 5) && (k <= 23);
            wend    = (m == 4) && (k <= 20);
            // A second start while busy must not disturb the running program.
            start      = (k == 10);
            start_addr = (k == 10) ? 10'h200 : 10'h040;
            tick();
            er = (m >= 1) && (m <= 3) && (k <= 19);
            ea = 10'(64 + m - 1);
            checks++;
            if (read !== er) begin errors++; $display("FAIL loop_read k=%0d got %0b want %0b", k, read, er); end
            if (er) begin
                checks++;
                if (addr !== ea) begin errors++; $display("FAIL loop_addr k=%0d got %h want %h", k, addr, ea); end
            end
            checks++;
            if (done !== (k == 24)) begin errors++; $display("FAIL loop_done k=%0d got %0b want %0b", k, done, (k == 24)); end
            checks++;
            if (busy !== (k <= 24)) begin errors++; $display("FAIL loop_busy k=%0d got %0b want %0b", k, busy, (k <= 24)); end
        end
        start = 1'b0; consume = 1'b0; wend = 1'b0; loop_count = 8'd0;
    endtask
`endif

    task automatic test_credit_err();
        logic [ADDR_W-1:0] ea;
        // Consume while idle with all credits present.
        consume = 1'b1;
        tick();
        consume = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
        tick(); tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
        // Credits must still be 4: with one read+consume overlap at k=3,
        // exactly five reads fit before the counter runs dry.
        pulse_start(10'h100);
        for (int k = 1; k <= 13; k++) begin
            consume = (k == 3) || (k >= 8 && k <= 11);
            wend    = (k == 7);
            tick();
            ea = 10'(256 + k - 1);
            checks++;
            if (read !== (k <= 5)) begin errors++; $display("FAIL credit_read k=%0d got %0b want %0b", k, read, (k <= 5)); end
            if (k <= 5) begin
                checks++;
                if (addr !== ea) begin errors++; $display("FAIL credit_addr k=%0d got %h want %h", k, addr, ea); end
            end
            checks++;
            if (done !== (k == 12)) begin errors++; $display("FAIL credit_done k=%0d got %0b want %0b", k, done, (k == 12)); end
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL credit_err k=%0d got %0b want 1", k, err); end
        end
        consume = 1'b0; wend = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        logic [ADDR_W-1:0] ea;
        pulse_start(10'h080);
        tick(); tick();
        checks++; if (read !== 1'b1) begin errors++; $display("FAIL mid_read_before got %0b want 1", read); end
        #2;
        reset_poweron = 1'b0;
        #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL mid_read got %0b want 0", read); end
        checks++; if (addr !== 10'h000) begin errors++; $display("FAIL mid_addr got %h want 000", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", done); end
        checks++; if (err  !== 1'b0) begin errors++; $display("FAIL mid_err got %0b want 0", err); end
        #2;
        reset_poweron = 1'b1;
        tick();
        pulse_start(10'h0C0);
        for (int k = 1; k <= 11; k++) begin
            consume = (k >= 6 && k <= 9);
            wend    = (k == 5);
            tick();
            ea = 10'(192 + k - 1);
            checks++;
            if (read !== (k <= 4)) begin errors++; $display("FAIL restart_read k=%0d got %0b want %0b", k, read, (k <= 4)); end
            if (k <= 4) begin
                checks++;
                if (addr !== ea) begin errors++; $display("FAIL restart_addr k=%0d got %h want %h", k, addr, ea); end
            end
            checks++;
            if (done !== (k == 10)) begin errors++; $display("FAIL restart_done k=%0d got %0b want %0b", k, done, (k == 10)); end
            checks++;
            if (busy !== (k <= 10)) begin errors++; $display("FAIL restart_busy k=%0d got %0b want %0b", k, busy, (k <= 10)); end
        end
        consume = 1'b0; wend = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL restart_err got %0b want 0", err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
`ifdef WU_FETCH_LOOP_EN
        test_loop();
`endif
        test_credit_err();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wu_fetch.md
# wu_fetch

Work-unit (WU) instruction fetch sequencer for the manager. On a start command it issues a stream of read requests into the WU instruction memory, one address per cycle, and honours the memory's stall. It keeps a credit count so the downstream decode skid buffer never overflows. Fetch stops when decode reports end-of-program; the block then drains in-flight words and signals completion to the manager controller.

## Interface
Parameters:
- ADDR_W, default 10: WU address width; must equal the width of `MGR_WU_ADDRESS_RANGE`.
- CREDITS, default 4: decode skid-buffer depth, i.e. the maximum number of read words not yet consumed. Legal range 3..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_poweron  in  1  asynchronous, active-low reset.
- mcntl__wuf__start  in  1  single-cycle start pulse.
- mcntl__wuf__start_addr  in  ADDR_W  first WU address; sampled with start.
- mcntl__wuf__loop_count  in  8  extra passes; sampled with start. Present only with WU_FETCH_LOOP_EN.
- wuf__mcntl__busy  out  1  high in any state other than IDLE.
- wuf__mcntl__done  out  1  one-cycle pulse when the program has fully drained.
- wuf__mcntl__err  out  1  sticky credit-overflow error; cleared only by reset.
- wuf__wum__addr  out  ADDR_W  read address, registered.
- wuf__wum__read  out  1  read strobe, registered; one word per high cycle.
- wum__wuf__stall  in  1  memory/decode backpressure; high out of reset.
- wud__wuf__consume  in  1  decode retired one word from its skid buffer.
- wud__wuf__end  in  1  decode saw the last instruction of the program (pulse).

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: on start, load pc = start_addr, load loop_rem = loop_count, and go to FETCH. Start pulses in any other state are ignored.
- FETCH: read issues on a cycle when stall == 0 and credits > 0. When it issues, addr = pc and pc increments by 1. pc wraps from 2^ADDR_W-1 to 0.
- FETCH to DRAIN: on wud__wuf__end. No read issues in the same cycle as end or after it.
- DRAIN: wait until credits == CREDITS; this covers overfetched words, which decode discards by consuming them.
  - If loop_rem != 0: decrement loop_rem, set pc = start_addr, return to FETCH.
  - Otherwise go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Credit counter, width 4:
  - Reset value CREDITS.
  - Decrements on an issued read; increments on consume.
  - Read and consume in the same cycle leave it unchanged.
  - Consume while credits == CREDITS with no read that cycle: credits hold and err sets.
- wud__wuf__end outside FETCH is ignored.
- Reset asserted mid-operation, asynchronously: state = IDLE, credits = CREDITS, pc = 0, loop_rem = 0. All outputs are 0: busy, done, err, read, addr.

## Timing
- Start sampled at edge N: busy = 1 and read = 1 with addr = start_addr after edge N+1, provided stall was 0 at edge N+1.
- Sustained throughput is 1 read per cycle while stall == 0 and credits > 0.
- Stall and credits are sampled at the same edge that registers read. A stall appearing at edge K therefore suppresses the read from edge K onward. Reads already launched are covered by credits.
- Memory data reaches decode 2 cycles after read. The CREDITS >= 3 requirement covers this latency.
- End sampled at edge E: read = 0 from edge E onward.
- Done pulses 1 cycle after the DRAIN exit condition holds; busy falls on the same edge that done falls.

## Configuration
- WU_FETCH_LOOP_EN defined: the mcntl__wuf__loop_count port and the loop_rem register exist. The program executes loop_count+1 passes, each starting at start_addr.
- WU_FETCH_LOOP_EN undefined: the port and register are absent, loop_rem is treated as 0, and DRAIN always exits to DONE (single pass).

## Test plan
- Reset then start with start_addr = 0x010, stall = 0, consume every cycle from the third read onward, end after the 6th word consumed. Required: read addrs 0x010, 0x011, … continuous; credits never 0; done pulses once; busy falls.
- Stall high for 5 cycles mid-stream, starting at 0x020 with no consume. Required: exactly 4 reads (0x020-0x023) and no further read until consume. Addresses resume with no gap or duplicate.
- start_addr = 0x3FE, ADDR_W = 10. Required: addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Consume with credits == CREDITS. Required: err = 1 and stays 1, credits stay 4. Same cycle read + consume: credits unchanged.
- WU_FETCH_LOOP_EN, loop_count = 2, 3-word program at 0x040. Required: addresses 0x040-0x042 fetched three times, a single done at the end; start during busy ignored.
- Reset asserted while in FETCH. Required: read, addr, busy, done, err all 0 immediately (asynchronously); the next start begins cleanly at its start_addr.
